// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults and the sync-decoder lock state encoding.
package vga_timing_pkg;

  localparam int H_TOTAL_DEF     = 800;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_BP_DEF        = 48;
  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_TOTAL_DEF     = 525;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_BP_DEF        = 33;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int LOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Synchronises one active-low sync input and flags its falling edge as a 1-cycle pulse.
module vga_sync_edge (
  input  logic clk_div,
  input  logic reset_n,
  input  logic sync,
  output logic fall
);

  logic sync_q1;
  logic sync_q2;
  logic sync_q3;

  // Reset to 1 so an idle (high) line never produces a spurious edge.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      sync_q3 <= 1'b1;
    end else begin
      sync_q1 <= sync;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  assign fall = sync_q3 & ~sync_q2;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from incoming VGA syncs and tracks timing lock over whole frames.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic        clk_div,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        display_active,
  output logic        frame_start,
  output logic        locked,
  output sync_state_e sync_state
);

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_LIMIT  = 16'(2 * H_TOTAL);
  localparam logic [15:0] V_LIMIT  = 16'(2 * V_TOTAL);
  localparam logic [15:0] H_START  = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_END    = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_START  = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_END    = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [7:0]  GOOD_TGT = 8'(LOCK_FRAMES);

  logic        hs_fall;
  logic        vs_fall;
  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic        line_err;
  logic        skip_check;
  logic [7:0]  good_cnt;
  logic [7:0]  good_next;
  sync_state_e state;
  sync_state_e state_next;

  logic line_bad;
  logic frame_ok;
  logic timeout;
  logic h_vis;
  logic v_vis;

  vga_sync_edge u_hs_edge (
    .clk_div (clk_div),
    .reset_n (reset_n),
    .sync    (hsync),
    .fall    (hs_fall)
  );

  vga_sync_edge u_vs_edge (
    .clk_div (clk_div),
    .reset_n (reset_n),
    .sync    (vsync),
    .fall    (vs_fall)
  );

  // A coincident line check is folded into the same edge's frame verdict.
  assign line_bad = hs_fall & ~skip_check & (h_cnt != H_LAST);
  assign frame_ok = ~(line_err | line_bad) & (v_cnt == V_LAST);
  assign timeout  = (state != SEARCH) & ((h_cnt >= H_LIMIT) | (v_cnt >= V_LIMIT));
  assign h_vis    = (h_cnt >= H_START) & (h_cnt < H_END);
  assign v_vis    = (v_cnt >= V_START) & (v_cnt < V_END);

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_next = ACQUIRE;
          good_next  = 8'd0;
        end
      end
      ACQUIRE: begin
        if (timeout) begin
          state_next = SEARCH;
        end else if (vs_fall) begin
          if (frame_ok) begin
            good_next = good_cnt + 8'd1;
            if (good_cnt + 8'd1 == GOOD_TGT) state_next = LOCKED;
          end else begin
            good_next = 8'd0;
          end
        end
      end
      LOCKED: begin
        if (timeout | (vs_fall & ~frame_ok)) state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      good_cnt   <= 8'd0;
      h_cnt      <= 16'd0;
      v_cnt      <= 16'd0;
      line_err   <= 1'b0;
      skip_check <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      if (hs_fall) h_cnt <= 16'd0;
      else if (h_cnt != 16'hFFFF) h_cnt <= h_cnt + 16'd1;
      if (vs_fall) v_cnt <= 16'd0;
      else if (hs_fall && v_cnt != 16'hFFFF) v_cnt <= v_cnt + 16'd1;
      if (vs_fall) line_err <= 1'b0;
      else if (line_bad) line_err <= 1'b1;
      // The line in progress when the first vsync is seen has unknown history.
      if (state == SEARCH && vs_fall) skip_check <= 1'b1;
      else if (hs_fall) skip_check <= 1'b0;
    end
  end

  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      pixel_x        <= 16'd0;
      pixel_y        <= 16'd0;
      display_active <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      pixel_x        <= h_vis ? h_cnt - H_START : 16'd0;
      pixel_y        <= v_vis ? v_cnt - V_START : 16'd0;
      display_active <= (state == LOCKED) & h_vis & v_vis;
      frame_start    <= vs_fall & (state == LOCKED);
    end
  end

  assign locked     = (state == LOCKED);
  assign sync_state = state;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder with reduced timing: model checked every cycle plus literal pins.
module tb_vga_sync_decoder;
  import vga_timing_pkg::*;

  localparam int HT = 40;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HA = 28;
  localparam int VT = 20;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 12;
  localparam int LF = 2;

  localparam int M_SEARCH  = 0;
  localparam int M_ACQUIRE = 1;
  localparam int M_LOCKED  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hsync;
  logic        vsync;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic        display_active;
  logic        frame_start;
  logic        locked;
  sync_state_e sync_state;

  int vectors = 0;
  int miscompares = 0;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .clk_div        (clk),
    .reset_n        (reset_n),
    .hsync          (hsync),
    .vsync          (vsync),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .display_active (display_active),
    .frame_start    (frame_start),
    .locked         (locked),
    .sync_state     (sync_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts come from cycle stamps of sync edges seen 3 samples late.
  int cyc = 0;
  int last_hs = 0;
  int vlines = 0;
  logic [2:0] hs_seen = 3'b111;
  logic [2:0] vs_seen = 3'b111;
  int m_st = M_SEARCH;
  int m_good = 0;
  bit m_lerr = 0;
  bit m_skip = 0;
  int exp_px = 0, exp_py = 0, exp_da = 0, exp_fs = 0, exp_lk = 0, exp_st = 0;

  always @(posedge clk or negedge reset_n) begin
    int h, v, n_st;
    bit hev, vev, hvis, vvis, bad, ok, tmo;
    if (!reset_n) begin
      cyc = 0; last_hs = 0; vlines = 0;
      hs_seen = 3'b111; vs_seen = 3'b111;
      m_st = M_SEARCH; m_good = 0; m_lerr = 0; m_skip = 0;
      exp_px = 0; exp_py = 0; exp_da = 0; exp_fs = 0; exp_lk = 0; exp_st = M_SEARCH;
    end else begin
      cyc++;
      h = cyc - 1 - last_hs;
      if (h > 65535) h = 65535;
      v = (vlines > 65535) ? 65535 : vlines;
      hev = hs_seen[2] & ~hs_seen[1];
      vev = vs_seen[2] & ~vs_seen[1];
      hs_seen = {hs_seen[1:0], hsync};
      vs_seen = {vs_seen[1:0], vsync};
      hvis = (h >= HS + HB) && (h < HS + HB + HA);
      vvis = (v >= VS + VB) && (v < VS + VB + VA);
      exp_px = hvis ? h - (HS + HB) : 0;
      exp_py = vvis ? v - (VS + VB) : 0;
      exp_da = (m_st == M_LOCKED && hvis && vvis) ? 1 : 0;
      exp_fs = (vev && m_st == M_LOCKED) ? 1 : 0;
      bad = hev && !m_skip && (h != HT - 1);
      ok  = !(m_lerr || bad) && (v == VT - 1);
      tmo = (m_st != M_SEARCH) && (h >= 2 * HT || v >= 2 * VT);
      n_st = m_st;
      if (m_st == M_SEARCH) begin
        if (vev) begin n_st = M_ACQUIRE; m_good = 0; end
      end else if (tmo) begin
        n_st = M_SEARCH;
      end else if (vev) begin
        if (m_st == M_LOCKED) begin
          if (!ok) n_st = M_SEARCH;
        end else if (ok) begin
          m_good++;
          if (m_good == LF) n_st = M_LOCKED;
        end else begin
          m_good = 0;
        end
      end
      if (m_st == M_SEARCH && vev) m_skip = 1;
      else if (hev) m_skip = 0;
      m_lerr = vev ? 0 : (m_lerr | bad);
      if (hev) last_hs = cyc;
      if (vev) vlines = 0;
      else if (hev) vlines++;
      m_st = n_st;
      exp_lk = (m_st == M_LOCKED) ? 1 : 0;
      exp_st = m_st;
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    check("pixel_x", int'(pixel_x), exp_px);
    check("pixel_y", int'(pixel_y), exp_py);
    check("display_active", int'(display_active), exp_da);
    check("frame_start", int'(frame_start), exp_fs);
    check("locked", int'(locked), exp_lk);
    check("sync_state", int'(sync_state), exp_st);
  end

  // monitor feeding the hand-computed literal pins
  bit mon_on = 0;
  bit seen_da = 0;
  int lock_at = -1, last_fs = -1, fs_gap = -1;
  int first_px = -1, first_py = -1, max_px = -1, max_py = -1;

  always @(negedge clk) begin
    if (mon_on && reset_n) begin
      if (locked && lock_at < 0) lock_at = cyc;
      if (frame_start) begin
        if (last_fs >= 0) fs_gap = cyc - last_fs;
        last_fs = cyc;
      end
      if (display_active) begin
        if (!seen_da) begin
          first_px = int'(pixel_x);
          first_py = int'(pixel_y);
          seen_da = 1;
        end
        if (int'(pixel_x) > max_px) max_px = int'(pixel_x);
        if (int'(pixel_y) > max_py) max_py = int'(pixel_y);
      end
    end
  end

  // driver tasks: generator timing, syncs low at the start of line/frame
  task automatic drive_px(input int x, input int y);
    @(negedge clk);
    hsync = (x < HS) ? 1'b0 : 1'b1;
    vsync = (y < VS) ? 1'b0 : 1'b1;
  endtask

  task automatic drive_line(input int y, input int len);
    for (int x = 0; x < len; x++) drive_px(x, y);
  endtask

  task automatic drive_frame(input int lines, input int short_idx, input int short_len);
    for (int y = 0; y < lines; y++) drive_line(y, (y == short_idx) ? short_len : HT);
  endtask

  initial begin
    reset_n = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mon_on = 1;

    // nominal timing: lock, then steady frames
    repeat (5) drive_frame(VT, -1, HT);
    for (int y = 0; y < 8; y++) drive_line(y, HT);
    for (int x = 0; x < 15; x++) drive_px(x, 8);
    mon_on = 0;
    check("lock_cycle", lock_at, 1604);
    check("frame_start_gap", fs_gap, 800);
    check("first_pixel_x", first_px, 0);
    check("first_pixel_y", first_py, 0);
    check("last_pixel_x", max_px, 27);
    check("last_pixel_y", max_py, 11);
    check("pre_reset_active", int'(display_active), 1);

    // asynchronous reset during active video
    #2 reset_n = 1'b0;
    #1;
    check("rst_pixel_x", int'(pixel_x), 0);
    check("rst_pixel_y", int'(pixel_y), 0);
    check("rst_display_active", int'(display_active), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_state", int'(sync_state), 0);
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // lock, one 39-clock line while locked, then relock
    repeat (3) drive_frame(VT, -1, HT);
    drive_frame(VT, 10, HT - 1);
    repeat (5) drive_frame(VT, -1, HT);
    check("relocked_after_line_fault", int'(locked), 1);

    // loss of sync: hsync held high
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (150) @(negedge clk);
    check("loss_locked", int'(locked), 0);
    check("loss_display_active", int'(display_active), 0);

    // 19-line frame while acquiring
    drive_frame(VT, -1, HT);
    drive_frame(VT - 1, -1, HT);
    drive_frame(VT, -1, HT);
    drive_line(0, HT);
    check("short_frame_no_lock", int'(locked), 0);
    for (int y = 1; y < VT; y++) drive_line(y, HT);
    drive_frame(VT, -1, HT);
    for (int y = 0; y < 3; y++) drive_line(y, HT);
    check("relock_after_short_frame", int'(locked), 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
